tmr_degrading_voter: RTL and testbench

Parametrised successor to the fixed-width combinational TMR output voter. Bitwise 2-of-3 majority over a WIDTH-bit triplicated bus, with per-replica error counters and sticky fault tracking. A 3-state mode FSM (TMR -> DMR -> FAIL) excludes a chronically faulty replica and flags an uncorrectable condition. One instance sits on each triplicated output group of a hardened block; the fault outputs feed a core-level fault aggregator.

---
 rtl/tmr_degrading_voter.sv | 177 +++++++++++++++++
 tb/tb_tmr_degrading_voter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_degrading_voter.sv
// Purpose: bitwise 2-of-3 output voter that degrades TMR -> DMR -> FAIL as replicas misbehave.
// Latency: vote_o/detected_o combinational (1 cycle when TMR_VOTER_OUT_REG_EN is defined); state updates 1 cycle.
// Backpressure: none; a new triplicated word is accepted every cycle, and valid_i only gates fault bookkeeping.
module tmr_degrading_voter #(
    parameter int WIDTH  = 32,
    parameter int CNT_W  = 8,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic [WIDTH-1:0] in3_i,
    input  logic             valid_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] vote_o,
    output logic             detected_o,
    output logic [1:0]       mode_o,
    output logic [1:0]       excl_id_o,
    output logic [2:0]       fault_sticky_o,
    output logic [CNT_W-1:0] err_cnt1_o,
    output logic [CNT_W-1:0] err_cnt2_o,
    output logic [CNT_W-1:0] err_cnt3_o,
    output logic             fail_o
);

    // A threshold of 0 would exclude a replica before it ever failed; one
    // above the saturation value could never be reached.
    if (THRESH < 1 || longint'(THRESH) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_thresh
        $error("tmr_degrading_voter: THRESH outside 1..2^CNT_W-1");
    end

    typedef enum logic [1:0] {
        MODE_TMR  = 2'd0,
        MODE_DMR  = 2'd1,
        MODE_FAIL = 2'd2
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);
    localparam logic [1:0]       EXCL_NONE = 2'd3;

    mode_t            mode_q, mode_d;
    logic [1:0]       excl_q, excl_d;
    logic [2:0]       sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    logic [WIDTH-1:0] maj;
    logic [WIDTH-1:0] rep_a;
    logic [WIDTH-1:0] rep_b;
    logic [2:0]       keep_mask;
    logic [2:0]       dis;
    logic [WIDTH-1:0] vote_c;
    logic             det_c;

    assign maj       = (in1_i & in2_i) | (in1_i & in3_i) | (in2_i & in3_i);
    assign keep_mask = ~(3'b001 << excl_q);

    // Pick the surviving pair once a replica is excluded; A is the lower index.
    always_comb begin
        rep_a = in1_i;
        rep_b = in2_i;
        case (excl_q)
            2'd0: begin
                rep_a = in2_i;
                rep_b = in3_i;
            end
            2'd1: begin
                rep_a = in1_i;
                rep_b = in3_i;
            end
            default: ;
        endcase
    end

    // Per-replica disagreement: against the majority in TMR, pairwise A/B afterwards.
    always_comb begin
        dis = 3'b000;
        if (mode_q == MODE_TMR) begin
            dis[0] = (in1_i != maj);
            dis[1] = (in2_i != maj);
            dis[2] = (in3_i != maj);
        end else if (rep_a != rep_b) begin
            dis = keep_mask;
        end
    end

    assign vote_c = (mode_q == MODE_TMR) ? maj : rep_a;
    assign det_c  = ~rst & valid_i & (|dis);

    // Next-state: clear first, then valid-gated counting and mode degradation.
    always_comb begin
        mode_d   = mode_q;
        excl_d   = excl_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            mode_d   = MODE_TMR;
            excl_d   = EXCL_NONE;
            sticky_d = 3'b000;
            cnt_d    = '{default: '0};
        end else if (valid_i) begin
            for (int k = 0; k < 3; k++) begin
                if (dis[k]) begin
                    if (cnt_q[k] != CNT_MAX) begin
                        cnt_d[k] = cnt_q[k] + CNT_W'(1);
                    end
                    sticky_d[k] = 1'b1;
                end
            end
            case (mode_q)
                MODE_TMR: begin
                    // Descending scan so the lowest index wins a tie.
                    for (int k = 2; k >= 0; k--) begin
                        if (dis[k] && (cnt_d[k] >= THR)) begin
                            mode_d = MODE_DMR;
                            excl_d = 2'(k);
                        end
                    end
                end
                MODE_DMR: begin
                    if (|dis) begin
                        mode_d = MODE_FAIL;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register; reset overrides every other update.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_TMR;
            excl_q   <= EXCL_NONE;
            sticky_q <= 3'b000;
            cnt_q    <= '{default: '0};
        end else begin
            mode_q   <= mode_d;
            excl_q   <= excl_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef TMR_VOTER_OUT_REG_EN
    logic [WIDTH-1:0] vote_q;
    logic             det_q;

    // Retime the voted word and the detect flag by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vote_q <= '0;
            det_q  <= 1'b0;
        end else begin
            vote_q <= vote_c;
            det_q  <= det_c;
        end
    end

    assign vote_o     = vote_q;
    assign detected_o = det_q;
`else
    assign vote_o     = vote_c;
    assign detected_o = det_c;
`endif

    assign mode_o         = mode_q;
    assign excl_id_o      = excl_q;
    assign fault_sticky_o = sticky_q;
    assign err_cnt1_o     = cnt_q[0];
    assign err_cnt2_o     = cnt_q[1];
    assign err_cnt3_o     = cnt_q[2];
    assign fail_o         = (mode_q == MODE_FAIL);

endmodule

// File: tb/tb_tmr_degrading_voter.sv
// Bench for tmr_degrading_voter: three instances (default, THRESH=1, CNT_W=2/THRESH=3) on shared inputs.
// Expected vote/detect go into a scoreboard queue at drive time and are popped at the output sample point.
// Registered state is compared inline by each scenario task right after the capturing edge.
module tb_tmr_degrading_voter;

`ifdef TMR_VOTER_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic [31:0] in3 = '0;
    logic        valid = 1'b0;
    logic        clr = 1'b0;

    logic [31:0] vote0, vote1, vote2;
    logic        det0, det1, det2;
    logic [1:0]  mode0, mode1, mode2;
    logic [1:0]  excl0, excl1, excl2;
    logic [2:0]  stk0, stk1, stk2;
    logic [7:0]  c01, c02, c03, c11, c12, c13;
    logic [1:0]  c21, c22, c23;
    logic        fail0, fail1, fail2;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] vote;
        logic        det;
        logic [1:0]  sel;
    } sb_t;

    typedef struct packed {
        logic [1:0] mode;
        logic [1:0] excl;
        logic [2:0] sticky;
        logic [7:0] c1;
        logic [7:0] c2;
        logic [7:0] c3;
        logic       fail;
    } st_t;

    sb_t q[$];
    sb_t e;
    logic [31:0] gv;
    logic        gd;
    st_t st, ex;

    always #5 clk = ~clk;

    tmr_degrading_voter #(.WIDTH(32), .CNT_W(8), .THRESH(4)) dut0 (
        .clk(clk), .rst(rst), .in1_i(in1), .in2_i(in2), .in3_i(in3),
        .valid_i(valid), .clr_i(clr), .vote_o(vote0), .detected_o(det0),
        .mode_o(mode0), .excl_id_o(excl0), .fault_sticky_o(stk0),
        .err_cnt1_o(c01), .err_cnt2_o(c02), .err_cnt3_o(c03), .fail_o(fail0));

    tmr_degrading_voter #(.WIDTH(32), .CNT_W(8), .THRESH(1)) dut1 (
        .clk(clk), .rst(rst), .in1_i(in1), .in2_i(in2), .in3_i(in3),
        .valid_i(valid), .clr_i(clr), .vote_o(vote1), .detected_o(det1),
        .mode_o(mode1), .excl_id_o(excl1), .fault_sticky_o(stk1),
        .err_cnt1_o(c11), .err_cnt2_o(c12), .err_cnt3_o(c13), .fail_o(fail1));

    tmr_degrading_voter #(.WIDTH(32), .CNT_W(2), .THRESH(3)) dut2 (
        .clk(clk), .rst(rst), .in1_i(in1), .in2_i(in2), .in3_i(in3),
        .valid_i(valid), .clr_i(clr), .vote_o(vote2), .detected_o(det2),
        .mode_o(mode2), .excl_id_o(excl2), .fault_sticky_o(stk2),
        .err_cnt1_o(c21), .err_cnt2_o(c22), .err_cnt3_o(c23), .fail_o(fail2));

    // Scoreboard: pop the expected vote/detect once the output latency has elapsed.
    always @(negedge clk) begin
        if (q.size() > LAT) begin
            e = q.pop_front();
            case (e.sel)
                2'd0:    begin gv = vote0; gd = det0; end
                2'd1:    begin gv = vote1; gd = det1; end
                default: begin gv = vote2; gd = det2; end
            endcase
            total++;
            if (gv !== e.vote || gd !== e.det) begin
                bad++;
                $display("FAIL vote_det dut%0d got vote=%h det=%b exp vote=%h det=%b",
                         e.sel, gv, gd, e.vote, e.det);
            end
        end
    end

    function automatic st_t get_st(input int sel);
        st_t s;
        case (sel)
            0:       s = '{mode0, excl0, stk0, c01, c02, c03, fail0};
            1:       s = '{mode1, excl1, stk1, c11, c12, c13, fail1};
            default: s = '{mode2, excl2, stk2, {6'b0, c21}, {6'b0, c22}, {6'b0, c23}, fail2};
        endcase
        return s;
    endfunction

    function automatic st_t mk(input logic [1:0] m, input logic [1:0] x, input logic [2:0] s,
                               input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        st_t r;
        r = '{m, x, s, a, b, c, (m == 2'd2)};
        return r;
    endfunction

    // Apply one cycle of stimulus, record the expected output, and step past the capturing edge.
    task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic v, input logic cl, input logic [31:0] ev, input logic ed,
                         input logic [1:0] sel);
        rst = r; in1 = a; in2 = b; in3 = c; valid = v; clr = cl;
        q.push_back(sb_t'{ev, ed, sel});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0);
        q.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 32'h1, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 2'd0);
        q.delete();
        rst = 1'b0;
        st = get_st(0); ex = mk(2'd0, 2'd3, 3'b000, 8'd0, 8'd0, 8'd0); total++;
        if (st !== ex) begin bad++; $display("FAIL reset_state got=%h exp=%h", st, ex); end
    endtask

    task automatic test_all_agree();
        for (int i = 0; i < 10; i++)
            drive(1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'hA5A5_A5A5, 1'b0, 2'd0);
        st = get_st(0); ex = mk(2'd0, 2'd3, 3'b000, 8'd0, 8'd0, 8'd0); total++;
        if (st !== ex) begin bad++; $display("FAIL all_agree_state got=%h exp=%h", st, ex); end
    endtask

    task automatic test_single_fault();
        for (int i = 0; i < 3; i++)
            drive(1'b0, 32'h0, 32'h1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 2'd0);
        st = get_st(0); ex = mk(2'd0, 2'd3, 3'b010, 8'd0, 8'd3, 8'd0); total++;
        if (st !== ex) begin bad++; $display("FAIL single_fault_3 got=%h exp=%h", st, ex); end
        drive(1'b0, 32'h0, 32'h1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 2'd0);
        st = get_st(0); ex = mk(2'd1, 2'd1, 3'b010, 8'd0, 8'd4, 8'd0); total++;
        if (st !== ex) begin bad++; $display("FAIL single_fault_excl got=%h exp=%h", st, ex); end
    endtask

    task automatic test_dmr_fail();
        drive(1'b0, 32'h0, 32'hFFFF_FFFF, 32'h5, 1'b1, 1'b0, 32'h0, 1'b1, 2'd0);
        st = get_st(0); ex = mk(2'd2, 2'd1, 3'b111, 8'd1, 8'd4, 8'd1); total++;
        if (st !== ex) begin bad++; $display("FAIL dmr_to_fail got=%h exp=%h", st, ex); end
        drive(1'b0, 32'h0, 32'hFFFF_FFFF, 32'h5, 1'b1, 1'b0, 32'h0, 1'b1, 2'd0);
        st = get_st(0); ex = mk(2'd2, 2'd1, 3'b111, 8'd2, 8'd4, 8'd2); total++;
        if (st !== ex) begin bad++; $display("FAIL fail_counting got=%h exp=%h", st, ex); end
        drive(1'b0, 32'h7, 32'h0, 32'h7, 1'b1, 1'b0, 32'h7, 1'b0, 2'd0);
        drive(1'b0, 32'h0, 32'h0, 32'h9, 1'b1, 1'b1, 32'h0, 1'b1, 2'd0);
        clr = 1'b0;
        st = get_st(0); ex = mk(2'd0, 2'd3, 3'b000, 8'd0, 8'd0, 8'd0); total++;
        if (st !== ex) begin bad++; $display("FAIL clr_state got=%h exp=%h", st, ex); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive(1'b0, 32'h1, 32'h0, 32'h80, 1'b1, 1'b0, 32'h0, 1'b1, 2'd1);
        st = get_st(1); ex = mk(2'd1, 2'd0, 3'b101, 8'd1, 8'd0, 8'd1); total++;
        if (st !== ex) begin bad++; $display("FAIL same_cycle_excl got=%h exp=%h", st, ex); end
        drive(1'b0, 32'h1, 32'h0, 32'h80, 1'b1, 1'b0, 32'h0, 1'b1, 2'd1);
        st = get_st(1); ex = mk(2'd2, 2'd0, 3'b111, 8'd1, 8'd1, 8'd2); total++;
        if (st !== ex) begin bad++; $display("FAIL same_cycle_dmr got=%h exp=%h", st, ex); end
    endtask

    task automatic test_valid_gate();
        do_reset();
        for (int i = 0; i < 5; i++)
            drive(1'b0, 32'h0, 32'h1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0);
        st = get_st(0); ex = mk(2'd0, 2'd3, 3'b000, 8'd0, 8'd0, 8'd0); total++;
        if (st !== ex) begin bad++; $display("FAIL valid_gate got=%h exp=%h", st, ex); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 3; i++)
            drive(1'b0, 32'h0, 32'h0, 32'h1, 1'b1, 1'b0, 32'h0, 1'b1, 2'd2);
        st = get_st(2); ex = mk(2'd1, 2'd2, 3'b100, 8'd0, 8'd0, 8'd3); total++;
        if (st !== ex) begin bad++; $display("FAIL sat_excl got=%h exp=%h", st, ex); end
        for (int i = 0; i < 3; i++)
            drive(1'b0, 32'h2, 32'h1, 32'h0, 1'b1, 1'b0, 32'h2, 1'b1, 2'd2);
        st = get_st(2); ex = mk(2'd2, 2'd2, 3'b111, 8'd3, 8'd3, 8'd3); total++;
        if (st !== ex) begin bad++; $display("FAIL sat_reach got=%h exp=%h", st, ex); end
        for (int i = 0; i < 3; i++)
            drive(1'b0, 32'h2, 32'h1, 32'h0, 1'b1, 1'b0, 32'h2, 1'b1, 2'd2);
        st = get_st(2); ex = mk(2'd2, 2'd2, 3'b111, 8'd3, 8'd3, 8'd3); total++;
        if (st !== ex) begin bad++; $display("FAIL sat_nowrap got=%h exp=%h", st, ex); end
    endtask

    task automatic test_rst_priority();
        do_reset();
        for (int i = 0; i < 4; i++)
            drive(1'b0, 32'h1, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 2'd0);
        st = get_st(0); ex = mk(2'd1, 2'd0, 3'b001, 8'd4, 8'd0, 8'd0); total++;
        if (st !== ex) begin bad++; $display("FAIL pre_rst_dmr got=%h exp=%h", st, ex); end
        drive(1'b1, 32'h0, 32'h3, 32'h4, 1'b1, 1'b1, 32'h3, 1'b0, 2'd0);
        q.delete();
        rst = 1'b0; clr = 1'b0;
        st = get_st(0); ex = mk(2'd0, 2'd3, 3'b000, 8'd0, 8'd0, 8'd0); total++;
        if (st !== ex) begin bad++; $display("FAIL rst_priority got=%h exp=%h", st, ex); end
        drive(1'b0, 32'h6, 32'h6, 32'h6, 1'b1, 1'b0, 32'h6, 1'b0, 2'd0);
        drive(1'b0, 32'hC3, 32'hC3, 32'h0, 1'b1, 1'b0, 32'hC3, 1'b1, 2'd0);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0);
    endtask

    initial begin
        test_reset();
        test_all_agree();
        test_single_fault();
        test_dmr_fail();
        test_same_cycle();
        test_valid_gate();
        test_saturate();
        test_rst_priority();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "timeout");
    end

endmodule
